// File: rtl/engine_state_ctrl.sv
// Global power/mode controller: powers up on a held-button edge, latches a settled
// mode-switch code into a driving mode, and shuts down on the power-off button or on idle timeout.
module engine_state_ctrl #(
    parameter int MODE_SETTLE_CYC  = 2_000_000,
    parameter int IDLE_TIMEOUT_CYC = 1_000_000_000,
    parameter int SYNC_STAGES      = 2
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       power_on_held,
    input  logic       power_off,
    input  logic       mode_signal1,
    input  logic       mode_signal2,
    input  logic       activity,
    output logic       engine_on,
    output logic [1:0] mode_out,
    output logic       mode_change,
    output logic [2:0] state_code,
    output logic [1:0] shutdown_cause
);
    localparam int SETTLE_W = (MODE_SETTLE_CYC > 1) ? $clog2(MODE_SETTLE_CYC) : 1;
    localparam int IDLE_W   = (IDLE_TIMEOUT_CYC > 1) ? $clog2(IDLE_TIMEOUT_CYC) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(MODE_SETTLE_CYC - 1);
    localparam logic [IDLE_W-1:0]   IDLE_LAST   = IDLE_W'(IDLE_TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SELECT = 3'd1,
        ST_MANUAL = 3'd2,
        ST_SEMI   = 3'd3,
        ST_AUTO   = 3'd4
    } state_t;

    state_t                   state_reg, state_next;
    logic [1:0]               code_prev_reg;
    logic [SETTLE_W-1:0]      settle_cnt_reg, settle_cnt_next;
    logic [IDLE_W-1:0]        idle_cnt_reg, idle_cnt_next;
    logic                     poh_prev_reg;
    logic                     engine_on_reg;
    logic [1:0]               mode_out_reg, mode_next;
    logic                     mode_change_reg;
    logic [1:0]               shutdown_cause_reg, cause_next;

    // Bit 2 carries power_off, bits 1:0 the mode switch code {s1, s2}.
    logic [SYNC_STAGES-1:0][2:0] sync_reg;
    logic                        poff_sync;
    logic [1:0]                  code_sync;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_head
                always_ff @(posedge sys_clk) begin
                    if (!rst_n) sync_reg[0] <= '0;
                    else        sync_reg[0] <= {power_off, mode_signal1, mode_signal2};
                end
            end else begin : g_tail
                always_ff @(posedge sys_clk) begin
                    if (!rst_n) sync_reg[gi] <= '0;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign poff_sync = sync_reg[SYNC_STAGES-1][2];
    assign code_sync = sync_reg[SYNC_STAGES-1][1:0];

    logic   code_stable;
    logic   settled;
    logic   idle_expired;
    state_t mode_target;

    always_comb begin
        state_next      = state_reg;
        cause_next      = shutdown_cause_reg;
        code_stable     = (code_sync == code_prev_reg);
        settled         = code_stable && (settle_cnt_reg == SETTLE_LAST);
        idle_expired    = !activity && (idle_cnt_reg == IDLE_LAST);
        mode_target     = code_sync[1] ? ST_AUTO : (code_sync[0] ? ST_SEMI : ST_MANUAL);
        settle_cnt_next = settle_cnt_reg;
        idle_cnt_next   = idle_cnt_reg;
        mode_next       = 2'b00;

        // Priority in powered states: button, then idle timeout, then mode change.
        case (state_reg)
            ST_OFF: begin
                if (power_on_held && !poh_prev_reg && !poff_sync) begin
                    state_next = ST_SELECT;
                    cause_next = 2'b00;
                end
            end
            default: begin
                if (poff_sync) begin
                    state_next = ST_OFF;
                    cause_next = 2'b01;
                end else if (state_reg == ST_MANUAL && idle_expired) begin
                    state_next = ST_OFF;
                    cause_next = 2'b10;
                end else if (settled && (state_reg == ST_SELECT || mode_target != state_reg)) begin
                    state_next = mode_target;
                end
            end
        endcase

        if (state_reg == ST_OFF || !code_stable)
            settle_cnt_next = '0;
        else if (settle_cnt_reg != SETTLE_LAST)
            settle_cnt_next = settle_cnt_reg + SETTLE_W'(1);

        if (state_reg != ST_MANUAL || state_next != ST_MANUAL || activity)
            idle_cnt_next = '0;
        else if (idle_cnt_reg != IDLE_LAST)
            idle_cnt_next = idle_cnt_reg + IDLE_W'(1);

        case (state_next)
            ST_MANUAL: mode_next = 2'b01;
            ST_SEMI:   mode_next = 2'b10;
            ST_AUTO:   mode_next = 2'b11;
            default:   mode_next = 2'b00;
        endcase
    end

    // poh_prev_reg resets high so a button held through reset is not seen as an edge.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_reg          <= ST_OFF;
            code_prev_reg      <= '0;
            settle_cnt_reg     <= '0;
            idle_cnt_reg       <= '0;
            poh_prev_reg       <= 1'b1;
            engine_on_reg      <= 1'b0;
            mode_out_reg       <= 2'b00;
            mode_change_reg    <= 1'b0;
            shutdown_cause_reg <= 2'b00;
        end else begin
            state_reg          <= state_next;
            code_prev_reg      <= code_sync;
            settle_cnt_reg     <= settle_cnt_next;
            idle_cnt_reg       <= idle_cnt_next;
            poh_prev_reg       <= power_on_held;
            engine_on_reg      <= (state_next != ST_OFF);
            mode_out_reg       <= mode_next;
            mode_change_reg    <= (mode_next != 2'b00) && (mode_next != mode_out_reg);
            shutdown_cause_reg <= cause_next;
        end
    end

    assign engine_on      = engine_on_reg;
    assign mode_out       = mode_out_reg;
    assign mode_change    = mode_change_reg;
    assign state_code     = state_reg;
    assign shutdown_cause = shutdown_cause_reg;

endmodule

// File: tb/tb_engine_state_ctrl.sv
// Bench for engine_state_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model built from the power/mode rules.
module tb_engine_state_ctrl;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 100;
    localparam int SYNC    = 2;

    logic       sys_clk;
    logic       rst_n;
    logic       power_on_held;
    logic       power_off;
    logic       mode_signal1;
    logic       mode_signal2;
    logic       activity;
    logic       engine_on;
    logic [1:0] mode_out;
    logic       mode_change;
    logic [2:0] state_code;
    logic [1:0] shutdown_cause;

    engine_state_ctrl #(
        .MODE_SETTLE_CYC  (SETTLE),
        .IDLE_TIMEOUT_CYC (TIMEOUT),
        .SYNC_STAGES      (SYNC)
    ) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .power_on_held  (power_on_held),
        .power_off      (power_off),
        .mode_signal1   (mode_signal1),
        .mode_signal2   (mode_signal2),
        .activity       (activity),
        .engine_on      (engine_on),
        .mode_out       (mode_out),
        .mode_change    (mode_change),
        .state_code     (state_code),
        .shutdown_cause (shutdown_cause)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: state numbers follow the display code (0 OFF .. 4 AUTO).
    int m_state, m_cause, m_mode, m_run, m_idle, m_last_code;
    bit m_mchg, m_prev_poh;
    int poff_h[SYNC];
    int code_h[SYNC];

    task automatic model_reset();
        m_state = 0; m_cause = 0; m_mode = 0; m_run = 0; m_idle = 0;
        m_last_code = 0; m_mchg = 0; m_prev_poh = 1;
        for (int i = 0; i < SYNC; i++) begin
            poff_h[i] = 0;
            code_h[i] = 0;
        end
    endtask

    task automatic model_step();
        int  poff_seen, code_seen, ns, tgt, prev_mode;
        bit  stable, timeout;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // The FSM sees each raw input as it was SYNC edges ago.
        poff_seen = poff_h[SYNC-1];
        code_seen = code_h[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) begin
            poff_h[i] = poff_h[i-1];
            code_h[i] = code_h[i-1];
        end
        poff_h[0] = int'(power_off);
        code_h[0] = int'({mode_signal1, mode_signal2});

        stable      = (code_seen == m_last_code);
        m_last_code = code_seen;
        prev_mode   = m_mode;

        // m_run: consecutive powered cycles with an unchanged code, including this one.
        if (m_state == 0)  m_run = 0;
        else if (stable)   m_run = (m_run + 1 > SETTLE) ? SETTLE : m_run + 1;
        else               m_run = 0;

        // m_idle: consecutive idle cycles spent in MANUAL, including this one.
        timeout = 0;
        if (m_state == 2) begin
            if (activity) m_idle = 0;
            else begin
                m_idle  = (m_idle + 1 > TIMEOUT) ? TIMEOUT : m_idle + 1;
                timeout = (m_idle >= TIMEOUT);
            end
        end else m_idle = 0;

        ns = m_state;
        if (m_state == 0) begin
            if (power_on_held && !m_prev_poh && poff_seen == 0) begin
                ns = 1; m_cause = 0;
            end
        end else if (poff_seen != 0) begin
            ns = 0; m_cause = 1;
        end else if (m_state == 2 && timeout) begin
            ns = 0; m_cause = 2;
        end else if (m_run >= SETTLE) begin
            tgt = (code_seen >= 2) ? 4 : ((code_seen == 1) ? 3 : 2);
            if (m_state == 1 || tgt != m_state) ns = tgt;
        end
        if (ns != 2) m_idle = 0;

        m_prev_poh = power_on_held;
        m_state    = ns;
        m_mode     = (ns == 2) ? 1 : (ns == 3) ? 2 : (ns == 4) ? 3 : 0;
        m_mchg     = (m_mode != 0) && (m_mode != prev_mode);
    endtask

    function automatic logic [31:0] dut_vec();
        return {23'd0, engine_on, mode_out, mode_change, state_code, shutdown_cause};
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v;
        v = {23'd0, (m_state != 0), m_mode[1:0], m_mchg, m_state[2:0], m_cause[1:0]};
        return v;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        #1;
        check("outs", dut_vec(), model_vec());
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_sw(input logic [1:0] c);
        mode_signal1 = c[1];
        mode_signal2 = c[0];
    endtask

    int pulses;
    int last_state;

    initial begin
        model_reset();
        rst_n = 1'b0; power_on_held = 1'b1; power_off = 1'b0; activity = 1'b1;
        set_sw(2'b01);

        // Reset, with the power button already held.
        tick_n(3);
        check("rst_engine_on", 32'(engine_on), 32'd0);
        check("rst_state", 32'(state_code), 32'd0);
        rst_n = 1'b1;
        tick_n(5);
        check("held_through_rst", 32'(state_code), 32'd0);
        $display("reset: state=%0d engine_on=%0d", state_code, engine_on);

        // Power-up into SELECT, then SEMI after the code settles.
        power_on_held = 1'b0; tick();
        power_on_held = 1'b1; tick();
        check("powerup_engine", 32'(engine_on), 32'd1);
        check("powerup_state", 32'(state_code), 32'd1);
        tick_n(7);
        check("select_hold", 32'(state_code), 32'd1);
        tick();
        check("semi_state", 32'(state_code), 32'd3);
        check("semi_mode", 32'(mode_out), 32'd2);
        check("semi_pulse", 32'(mode_change), 32'd1);
        tick();
        check("semi_pulse_end", 32'(mode_change), 32'd0);
        $display("power-up: state=%0d mode=%0d", state_code, mode_out);

        // Short glitch rejected, then a held change to AUTO.
        set_sw(2'b11); tick_n(5);
        set_sw(2'b01); tick_n(12);
        check("glitch_state", 32'(state_code), 32'd3);
        set_sw(2'b10);
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (mode_change) pulses++;
        end
        check("auto_state", 32'(state_code), 32'd4);
        check("auto_mode", 32'(mode_out), 32'd3);
        check("auto_pulses", 32'(pulses), 32'd1);
        $display("mode change: state=%0d pulses=%0d", state_code, pulses);

        // Idle timeout in MANUAL.
        set_sw(2'b00); tick_n(14);
        check("manual_state", 32'(state_code), 32'd2);
        activity = 1'b0; tick_n(99);
        activity = 1'b1; tick();
        check("idle_99", 32'(state_code), 32'd2);
        activity = 1'b0; tick_n(99);
        check("idle_before", 32'(state_code), 32'd2);
        tick();
        check("idle_off_state", 32'(state_code), 32'd0);
        check("idle_engine", 32'(engine_on), 32'd0);
        check("idle_cause", 32'(shutdown_cause), 32'd2);
        $display("idle timeout: state=%0d cause=%0d", state_code, shutdown_cause);

        // Level is not an edge: needs a fall and rise to repower.
        tick_n(5);
        check("level_off", 32'(state_code), 32'd0);
        power_on_held = 1'b0; tick();
        power_on_held = 1'b1; tick();
        check("repower_state", 32'(state_code), 32'd1);
        check("repower_cause", 32'(shutdown_cause), 32'd0);

        // Power-off arriving (after sync) on the same edge the idle timer expires.
        activity = 1'b1; tick_n(10);
        check("manual_again", 32'(state_code), 32'd2);
        activity = 1'b0; tick_n(97);
        power_off = 1'b1; tick();
        check("poff_e1", 32'(engine_on), 32'd1);
        tick();
        check("poff_e2", 32'(engine_on), 32'd1);
        tick();
        check("poff_e3", 32'(engine_on), 32'd0);
        check("poff_cause", 32'(shutdown_cause), 32'd1);
        $display("power-off: state=%0d cause=%0d", state_code, shutdown_cause);

        // Power-up blocked while power_off is held.
        power_on_held = 1'b0; tick();
        power_on_held = 1'b1; tick_n(3);
        check("poff_blocks", 32'(state_code), 32'd0);
        power_off = 1'b0; activity = 1'b1; tick_n(3);
        power_on_held = 1'b0; tick();
        power_on_held = 1'b1; tick();
        check("poff_released", 32'(state_code), 32'd1);

        // Reset mid-AUTO.
        set_sw(2'b10); tick_n(12);
        check("auto_again", 32'(state_code), 32'd4);
        rst_n = 1'b0; tick();
        check("rst_mid_auto", dut_vec(), 32'd0);
        rst_n = 1'b1; tick();
        $display("reset mid-auto: state=%0d engine_on=%0d", state_code, engine_on);

        // Randomized traffic, model compared every cycle.
        last_state = m_state;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) power_on_held = ~power_on_held;
            if ($urandom_range(0, 14) == 0) set_sw(2'($urandom_range(0, 3)));
            if (power_off) power_off = ($urandom_range(0, 3) != 0);
            else           power_off = ($urandom_range(0, 199) == 0);
            activity = ($urandom_range(0, 99) < 3);
            rst_n    = ($urandom_range(0, 999) != 0);
            tick();
            if (m_state != last_state) begin
                $display("rand cycle %0d: state %0d -> %0d cause=%0d", c, last_state, m_state, m_cause);
                last_state = m_state;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
